// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling register: step-mode encodings and field widths.
package scroll_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_ROL  = 2'b01,
    MODE_ROR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

endpackage

// File: rtl/tick_div.sv
// Programmable prescaler: emits one tick every in_DIV+1 enabled cycles.
module tick_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_EN,
  input  logic             in_CLR,
  input  logic [DIV_W-1:0] in_DIV,
  output logic             out_TICK
);

  logic [DIV_W-1:0] cnt;
  logic             hit_c;

  // The >= compare makes a lowered divisor fire on the very next enabled cycle.
  assign hit_c    = (cnt >= in_DIV);
  // Combinational so the parent register moves on the same edge the count expires.
  assign out_TICK = in_EN && !in_CLR && hit_c;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      cnt <= '0;
    end else if (in_CLR) begin
      cnt <= '0;
    end else if (in_EN) begin
      if (hit_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_reg.sv
// Scrolling shift/rotate register with prescaled stepping, position tracking
// and registered step / wrap pulses.
module scroll_reg
  import scroll_pkg::*;
#(
  parameter int unsigned     WIDTH = 16,
  parameter int unsigned     DIV_W = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                     in_CLK,
  input  logic                     in_RST,
  input  logic                     in_EN,
  input  logic                     in_LOAD,
  input  logic [WIDTH-1:0]         in_D,
  input  logic [MODE_W-1:0]        in_MODE,
  input  logic                     in_SER,
  input  logic [DIV_W-1:0]         in_DIV,
  output logic [WIDTH-1:0]         out_Q,
  output logic [$clog2(WIDTH)-1:0] out_POS,
  output logic                     out_STEP,
  output logic                     out_WRAP
);

  localparam int unsigned POS_W = $clog2(WIDTH);

  mode_e             mode;
  logic              tick_c;
  logic              pos_at_max;
  logic              pos_at_min;
  logic [POS_W-1:0]  pos_inc;
  logic [POS_W-1:0]  pos_dec;
  logic [WIDTH-1:0]  q_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              step_nxt;
  logic              wrap_nxt;

  // Load clears the prescaler so counting restarts aligned to the new data.
  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .in_CLK   (in_CLK),
    .in_RST   (in_RST),
    .in_EN    (in_EN),
    .in_CLR   (in_LOAD),
    .in_DIV   (in_DIV),
    .out_TICK (tick_c)
  );

  assign mode       = mode_e'(in_MODE);
  assign pos_at_max = (out_POS == POS_W'(WIDTH - 1));
  assign pos_at_min = (out_POS == '0);
  assign pos_inc    = pos_at_max ? '0 : out_POS + POS_W'(1);
  assign pos_dec    = pos_at_min ? POS_W'(WIDTH - 1) : out_POS - POS_W'(1);

  // Next-state: load wins over any tick; a tick in hold mode changes nothing.
  always_comb begin
    q_nxt    = out_Q;
    pos_nxt  = out_POS;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (in_LOAD) begin
      q_nxt   = in_D;
      pos_nxt = '0;
    end else if (tick_c) begin
      case (mode)
        MODE_ROL: begin
          q_nxt    = {out_Q[WIDTH-2:0], out_Q[WIDTH-1]};
          pos_nxt  = pos_inc;
          step_nxt = 1'b1;
          wrap_nxt = pos_at_max;
        end
        MODE_ROR: begin
          q_nxt    = {out_Q[0], out_Q[WIDTH-1:1]};
          pos_nxt  = pos_dec;
          step_nxt = 1'b1;
          wrap_nxt = pos_at_min;
        end
        MODE_SHL: begin
          q_nxt    = {out_Q[WIDTH-2:0], in_SER};
          pos_nxt  = pos_inc;
          step_nxt = 1'b1;
          wrap_nxt = pos_at_max;
        end
        default: begin
          q_nxt = out_Q;
        end
      endcase
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      out_Q    <= INIT;
      out_POS  <= '0;
      out_STEP <= 1'b0;
      out_WRAP <= 1'b0;
    end else begin
      out_Q    <= q_nxt;
      out_POS  <= pos_nxt;
      out_STEP <= step_nxt;
      out_WRAP <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_scroll_reg.sv
// Self-checking bench for scroll_reg (WIDTH=8, DIV_W=8, INIT=0).
module tb_scroll_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = $clog2(W);
  localparam int          M  = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic          ser;
  logic [W-1:0]  d;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  q;
  logic [PW-1:0] pos;
  logic          step;
  logic          wrap;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mq;
  int mpos;
  int mcnt;
  bit mstep;
  bit mwrap;

  always #5 clk = ~clk;

  scroll_reg #(
    .WIDTH (W),
    .DIV_W (DW),
    .INIT  (8'h00)
  ) dut (
    .in_CLK   (clk),
    .in_RST   (rst),
    .in_EN    (en),
    .in_LOAD  (load),
    .in_D     (d),
    .in_MODE  (mode),
    .in_SER   (ser),
    .in_DIV   (div),
    .out_Q    (q),
    .out_POS  (pos),
    .out_STEP (step),
    .out_WRAP (wrap)
  );

  task automatic model_reset();
    mq = 0; mpos = 0; mcnt = 0; mstep = 0; mwrap = 0;
  endtask

  // One rising edge of the behavioural model, from the rules in plain arithmetic.
  task automatic model_edge();
    bit tk;
    if (rst) begin
      model_reset();
    end else if (load) begin
      mq = int'(d); mpos = 0; mcnt = 0; mstep = 0; mwrap = 0;
    end else begin
      tk = en && (mcnt >= int'(div));
      if (en) mcnt = tk ? 0 : mcnt + 1;
      mstep = 0;
      mwrap = 0;
      if (tk && mode != 2'd0) begin
        mstep = 1;
        if (mode == 2'd1) begin
          mq = (mq * 2) % M + mq / (M / 2);
          mpos = (mpos + 1) % W;
          mwrap = (mpos == 0);
        end else if (mode == 2'd2) begin
          mq = mq / 2 + (mq % 2) * (M / 2);
          mpos = (mpos + W - 1) % W;
          mwrap = (mpos == W - 1);
        end else begin
          mq = (mq * 2) % M + int'(ser);
          mpos = (mpos + 1) % W;
          mwrap = (mpos == 0);
        end
      end
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; d = 8'hFF; mode = 2'd1; ser = 1'b0; div = '0;
    model_reset();
    #2;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
    checks++; if (pos !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    checks++; if (step !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_pulses: got step=%b wrap=%b expected 0 0", step, wrap); end
    step_clk(2);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_over_load: got %h expected 00", q); end
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [7:0] exp_q [8];
    int wraps;
    exp_q = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    load = 1'b1; d = 8'hA5; mode = 2'd1; div = 8'd0; en = 1'b1;
    step_clk(1);
    checks++; if (q !== 8'hA5 || pos !== 3'd0 || step !== 1'b0) begin errors++; $display("FAIL rol_load: got q=%h pos=%0d step=%b expected A5 0 0", q, pos, step); end
    load = 1'b0;
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      step_clk(1);
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL rol_q[%0d]: got %h expected %h", i, q, exp_q[i]); end
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL rol_step[%0d]: got %b expected 1", i, step); end
      if (wrap === 1'b1) wraps++;
    end
    checks++; if (pos !== 3'd0) begin errors++; $display("FAIL rol_pos_end: got %0d expected 0", pos); end
    checks++; if (wraps != 1) begin errors++; $display("FAIL rol_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_rotate_right();
    load = 1'b1; d = 8'h01; mode = 2'd2; div = 8'd3; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step_clk(1);
      checks++; if (step !== ((k % 4) == 0)) begin errors++; $display("FAIL ror_step[%0d]: got %b expected %b", k, step, (k % 4) == 0); end
      if (k == 4) begin
        checks++; if (q !== 8'h80 || pos !== 3'd7 || wrap !== 1'b1) begin errors++; $display("FAIL ror_first: got q=%h pos=%0d wrap=%b expected 80 7 1", q, pos, wrap); end
      end
      if (k == 8) begin
        checks++; if (q !== 8'h40 || pos !== 3'd6 || wrap !== 1'b0) begin errors++; $display("FAIL ror_second: got q=%h pos=%0d wrap=%b expected 40 6 0", q, pos, wrap); end
      end
    end
  endtask

  task automatic test_shift_fill();
    logic [7:0] exp_q [5];
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    load = 1'b1; d = 8'h00; mode = 2'd3; ser = 1'b1; div = 8'd0; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ser = 1'b0;
      step_clk(1);
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shl_q[%0d]: got %h expected %h", i, q, exp_q[i]); end
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; d = 8'h81; mode = 2'd1; div = 8'd0; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    step_clk(2);
    load = 1'b1; d = 8'h3C;
    step_clk(1);
    checks++; if (q !== 8'h3C || pos !== 3'd0 || step !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL load_on_tick: got q=%h pos=%0d step=%b wrap=%b expected 3C 0 0 0", q, pos, step, wrap); end
    en = 1'b0; d = 8'hC3;
    step_clk(1);
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL load_en_low: got %h expected C3", q); end
    load = 1'b0; en = 1'b1;
    step_clk(1);
    checks++; if (q !== 8'h87 || step !== 1'b1 || pos !== 3'd1) begin errors++; $display("FAIL after_load_step: got q=%h step=%b pos=%0d expected 87 1 1", q, step, pos); end
  endtask

  task automatic test_enable_hold();
    load = 1'b1; d = 8'h5A; mode = 2'd1; div = 8'd3; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    step_clk(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_clk(1);
      checks++; if (q !== 8'h5A || step !== 1'b0) begin errors++; $display("FAIL en_hold[%0d]: got q=%h step=%b expected 5A 0", i, q, step); end
    end
    en = 1'b1;
    step_clk(1);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL en_resume_early: got step=%b expected 0", step); end
    step_clk(1);
    checks++; if (step !== 1'b1 || q !== 8'hB4) begin errors++; $display("FAIL en_resume_tick: got step=%b q=%h expected 1 B4", step, q); end
  endtask

  task automatic test_div_change();
    load = 1'b1; d = 8'h11; mode = 2'd1; div = 8'd5; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL div_count[%0d]: got step=%b expected 0", i, step); end
    end
    div = 8'd1;
    step_clk(1);
    checks++; if (step !== 1'b1 || q !== 8'h22) begin errors++; $display("FAIL div_lowered: got step=%b q=%h expected 1 22", step, q); end
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 8'h12; mode = 2'd1; div = 8'd0; en = 1'b1;
    step_clk(1);
    load = 1'b0;
    step_clk(3);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (q !== 8'h00 || pos !== 3'd0 || step !== 1'b0) begin errors++; $display("FAIL async_reset: got q=%h pos=%0d step=%b expected 00 0 0", q, pos, step); end
    step_clk(1);
    rst = 1'b0; div = 8'd2;
    for (int k = 1; k <= 3; k++) begin
      step_clk(1);
      checks++; if (step !== (k == 3)) begin errors++; $display("FAIL release_step[%0d]: got %b expected %b", k, step, k == 3); end
    end
    checks++; if (pos !== 3'd1) begin errors++; $display("FAIL release_pos: got %0d expected 1", pos); end
  endtask

  task automatic test_random();
    load = 1'b1; d = W'($urandom); en = 1'b1;
    step_clk(1);
    for (int i = 0; i < 400; i++) begin
      load = ($urandom % 16) == 0;
      d    = W'($urandom);
      en   = ($urandom % 4) != 0;
      mode = 2'($urandom);
      ser  = 1'($urandom);
      div  = DW'($urandom % 4);
      step_clk(1);
      checks++; if (q !== W'(mq)) begin errors++; $display("FAIL rand_q[%0d]: got %h expected %h", i, q, W'(mq)); end
      checks++; if (pos !== PW'(mpos)) begin errors++; $display("FAIL rand_pos[%0d]: got %0d expected %0d", i, pos, mpos); end
      checks++; if (step !== mstep) begin errors++; $display("FAIL rand_step[%0d]: got %b expected %b", i, step, mstep); end
      checks++; if (wrap !== mwrap) begin errors++; $display("FAIL rand_wrap[%0d]: got %b expected %b", i, wrap, mwrap); end
    end
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_shift_fill();
    test_load_priority();
    test_enable_hold();
    test_div_change();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scroll_reg.md
SCROLL_REG -- requirements
Module: scroll_reg

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, on ports in_CLK and in_RST.
REQ-002 Parameter WIDTH: default 16; register width, allowed range 2..64.
REQ-003 Parameter DIV_W: default 8; width of the step-period field.
REQ-004 Parameter INIT: default 0; out_Q value under reset, WIDTH bits.
REQ-005 in_CLK  input  1  clock; all state updates on the rising edge.
REQ-006 in_RST  input  1  asynchronous, active-high reset.
REQ-007 in_EN  input  1  prescaler count enable.
REQ-008 in_LOAD  input  1  synchronous parallel load of in_D.
REQ-009 in_D  input  WIDTH  parallel load data.
REQ-010 in_MODE  input  2  step mode: 00 hold, 01 rotate left, 10 rotate right, 11 shift left with serial fill.
REQ-011 in_SER  input  1  serial fill bit, shifted into bit 0 in mode 11.
REQ-012 in_DIV  input  DIV_W  step period minus 1, in clock cycles.
REQ-013 out_Q  output  WIDTH  register contents.
REQ-014 out_POS  output  clog2(WIDTH)  scroll position, modulo WIDTH.
REQ-015 out_STEP  output  1  one-cycle pulse marking a step.
REQ-016 out_WRAP  output  1  one-cycle pulse marking a position wrap.

Function
REQ-017 Prescaler counter cnt (DIV_W bits) SHALL behave as follows while in_EN=1: tick when cnt >= in_DIV, then clear cnt to 0; otherwise increment cnt.
REQ-018 While in_EN=0, cnt SHALL hold and no tick SHALL be generated.
REQ-019 in_DIV=0 SHALL give one tick per enabled cycle.
REQ-020 Lowering in_DIV below the current cnt SHALL produce a tick on the next enabled cycle.
REQ-021 On a tick with in_MODE != 00, out_Q SHALL update on that edge:
- 01: out_Q <= {out_Q[WIDTH-2:0], out_Q[WIDTH-1]}.
- 10: out_Q <= {out_Q[0], out_Q[WIDTH-1:1]}.
- 11: out_Q <= {out_Q[WIDTH-2:0], in_SER}.
REQ-022 A tick in mode 00 SHALL leave out_Q, out_POS, out_STEP and out_WRAP unchanged and low where applicable; cnt SHALL still clear.
REQ-023 out_POS SHALL update on each step:
- Modes 01 and 11: increment, wrapping from WIDTH-1 to 0.
- Mode 10: decrement, wrapping from 0 to WIDTH-1.
REQ-024 out_STEP SHALL be registered and high exactly during the cycle following a step edge, aligned with the new out_Q.
REQ-025 out_WRAP SHALL be registered and high during the same cycle as out_STEP, only when that step wrapped out_POS.
REQ-026 in_LOAD=1 SHALL have priority over any tick, with these results on that edge:
- out_Q <= in_D.
- cnt <= 0 and out_POS <= 0.
- out_STEP and out_WRAP low the next cycle.
- in_EN is ignored.
REQ-027 in_MODE changes SHALL take effect on the next tick, with no glitch step.
REQ-028 Latency: one clock from a tick or load condition to the out_Q update; no combinational path from any input to any output.

Reset
REQ-029 While in_RST=1, outputs and state SHALL be forced immediately and asynchronously to: out_Q=INIT, cnt=0, out_POS=0, out_STEP=0, out_WRAP=0.
REQ-030 On in_RST deassertion mid-operation, counting SHALL restart from cnt=0; no tick SHALL be generated on the first edge after release unless in_DIV=0 and in_EN=1.

Structure
REQ-031 Mode encodings (MODE_HOLD, MODE_ROL, MODE_ROR, MODE_SHL) SHALL live in shared package scroll_pkg.
REQ-032 The prescaler SHALL be one sub-module, tick_div, with ports in_CLK, in_RST, in_EN, in_CLR, in_DIV and out_TICK.
REQ-033 The register and position logic SHALL remain in scroll_reg; no other sub-modules.

Verification (WIDTH=8, DIV_W=8, INIT=0)
REQ-034 Load 8'hA5, in_DIV=0, mode 01, in_EN=1:
- out_Q sequence 4B, 96, 2D, ...
- out_STEP high every cycle.
- After 8 steps out_Q=A5, out_POS=0, exactly one out_WRAP pulse.
REQ-035 Load 8'h01, in_DIV=3, mode 10:
- out_Q becomes 80 then 40, four cycles apart.
- out_POS goes 7 then 6; out_WRAP pulses on the first step only.
REQ-036 Load 8'h00, mode 11, in_SER=1, in_DIV=0 -> out_Q 01, 03, 07, 0F; in_SER=0 next -> 1E.
REQ-037 in_LOAD asserted on a tick cycle -> out_Q=in_D, out_POS=0, no out_STEP.
REQ-038 in_EN=0 for 10 cycles -> out_Q and cnt frozen.
REQ-039 in_DIV=5 with cnt=4, change in_DIV to 1 -> tick on the next edge.
REQ-040 Assert in_RST between clock edges during rotation -> out_Q=00 and out_POS=0 before the next edge; first step occurs in_DIV+1 enabled cycles after release.
